instr_fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V core. It sits directly upstream of decode and of `alu_cntrl1`, which consume its `instr_reg_fetch` output. The block owns the program counter and issues word requests to instruction memory. It buffers in-order responses in a small FIFO, hands them to decode over a valid/ready handshake, and handles branch/jump redirects by flushing buffered and in-flight fetches.

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/instr_fetch_unit_if.sv | 27 ++
 rtl/fetch_fifo.sv | 56 +++++
 rtl/instr_fetch_unit.sv | 95 +++++++++
 tb/tb_instr_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared core definitions: fetch FSM states, XLEN, the canonical NOP and the RV32 opcodes used by decode.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: imem request/response, redirect input and the decode-side valid/ready output.
interface instr_fetch_unit_if;
  import riscv_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr_reg_fetch;
  logic [XLEN-1:0] pc_fetch;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, instr_reg_fetch, pc_fetch,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, instr_reg_fetch, pc_fetch,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with flush (beats a same-cycle push); head is read straight from storage.
// Storage resets to zero so the head reads 0 out of reset.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Upstream credit accounting must always leave room for a write.
  assert property (@(posedge clk) disable iff (rst) (push && !flush) |-> !full);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, keeps outstanding+buffered fetches within DEPTH, drops stale responses after a redirect.
// Accept at t, response at t+1 -> instr_valid at t+2; decode backpressure stops new requests once credits run out.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t      state;
  logic [XLEN-1:0]   pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     stale;
  logic [CW-1:0]     out_next;
  logic [CW-1:0]     stale_dec;
  logic [CW-1:0]     dq_count;
  logic [CW-1:0]     pq_count;
  logic              dq_full, dq_empty, pq_full, pq_empty;
  logic [XLEN-1:0]   pq_head;
  logic [2*XLEN-1:0] dq_head;
  logic              req_fire;
  logic              rsp_keep;
  logic              deq;
  logic              unused_flags;

  assign bus.imem_req_valid  = (state == RUN) && ((outstanding + dq_count) < CW'(DEPTH));
  assign bus.imem_req_addr   = pc;
  assign bus.instr_valid     = !dq_empty;
  assign bus.pc_fetch        = dq_head[2*XLEN-1:XLEN];
  assign bus.instr_reg_fetch = dq_head[XLEN-1:0];

  assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_keep  = bus.imem_rsp_valid && !bus.redirect_valid && (stale == '0);
  assign deq       = !dq_empty && bus.instr_ready;
  assign out_next  = outstanding + CW'(req_fire) - CW'(bus.imem_rsp_valid);
  assign stale_dec = (bus.imem_rsp_valid && (stale != '0)) ? stale - CW'(1) : stale;

  assign unused_flags = &{1'b0, dq_full, pq_full, pq_empty, pq_count};

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(2*XLEN)) u_data_q (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .push_data ({pq_head, bus.imem_rsp_data}),
    .pop       (deq),
    .flush     (bus.redirect_valid),
    .head      (dq_head),
    .count     (dq_count),
    .full      (dq_full),
    .empty     (dq_empty)
  );

  // PCs of live requests only; a redirect empties it, so stale responses never pop it.
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_pc_q (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (pc),
    .pop       (rsp_keep),
    .flush     (bus.redirect_valid),
    .head      (pq_head),
    .count     (pq_count),
    .full      (pq_full),
    .empty     (pq_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= align_pc(RESET_PC);
      outstanding <= '0;
      stale       <= '0;
    end else begin
      outstanding <= out_next;
      if (state == BOOT) begin
        state <= RUN;
        if (bus.redirect_valid) pc <= align_pc(bus.redirect_pc);
      end else if (bus.redirect_valid) begin
        pc    <= align_pc(bus.redirect_pc);
        stale <= out_next;
        state <= (out_next != '0) ? DRAIN : RUN;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        stale <= stale_dec;
        if ((state == DRAIN) && (stale_dec == '0)) state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus ();
  instr_fetch_unit_if wbus ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(4)) u_wrap (.clk(clk), .rst(rst), .bus(wbus));

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // stimulus knobs
  int          rdy_pct;
  int          lat_min, lat_max;
  bit          dec_rdy_rand;
  logic        dec_rdy;
  int          redir_pct;
  bit          redir_req;
  bit          redir_on_rsp;
  logic [31:0] redir_target;
  int          n_rsp_redir;

  // memory model and reference model
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          last_due;
  logic [31:0] exp_pc, exp_req;
  int          max_out;

  logic [31:0] dlv_pc[$], dlv_ins[$], dlv_exp[$];
  int          dlv_cyc[$];
  logic [31:0] req_addr[$], req_exp[$];
  logic        s_req_valid;
  logic [31:0] s_req_addr;

  logic        w_pend;
  logic [31:0] w_addr;
  logic [31:0] w_pc[$], w_ins[$], w_req[$];
  int          w_cyc[$], w_req_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic idle_inputs();
    bus.imem_req_ready  = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.redirect_valid  = 1'b0; bus.redirect_pc    = '0;   bus.instr_ready   = 1'b0;
    wbus.imem_req_ready = 1'b0; wbus.imem_rsp_valid = 1'b0; wbus.imem_rsp_data = '0;
    wbus.redirect_valid = 1'b0; wbus.redirect_pc    = '0;   wbus.instr_ready   = 1'b0;
  endtask

  task automatic assert_reset();
    rst = 1'b1;
    idle_inputs();
    mq_addr.delete(); mq_due.delete(); last_due = 0;
    dlv_pc.delete(); dlv_ins.delete(); dlv_exp.delete(); dlv_cyc.delete();
    req_addr.delete(); req_exp.delete();
    w_pc.delete(); w_ins.delete(); w_cyc.delete(); w_req.delete(); w_req_cyc.delete();
    exp_pc = 32'h0; exp_req = 32'h0; max_out = 0; w_pend = 1'b0; w_addr = '0;
    rdy_pct = 100; lat_min = 1; lat_max = 1; dec_rdy_rand = 0; dec_rdy = 1'b1;
    redir_pct = 0; redir_req = 0; redir_on_rsp = 0; redir_target = '0; n_rsp_redir = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic release_reset();
    rst = 1'b0;
    cyc = 0;
  endtask

  // One clock: drive at the negedge, sample just after, then advance to the next negedge.
  task automatic cycle();
    bit          fire;
    logic [31:0] tgt;
    int          due;
    bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    bus.instr_ready = dec_rdy_rand ? 1'($urandom_range(1)) : dec_rdy;
    fire = redir_req;
    tgt  = redir_target;
    if (redir_on_rsp && bus.imem_rsp_valid) begin
      fire = 1; redir_on_rsp = 0; n_rsp_redir++;
    end
    if (redir_pct > 0 && $urandom_range(99) < redir_pct) begin
      fire = 1; tgt = $urandom;
    end
    redir_req = 0;
    bus.redirect_valid = fire;
    bus.redirect_pc    = tgt;
    wbus.imem_req_ready = 1'b1;
    wbus.imem_rsp_valid = w_pend;
    wbus.imem_rsp_data  = mem_word(w_addr);
    wbus.instr_ready    = 1'b1;
    wbus.redirect_valid = 1'b0;
    wbus.redirect_pc    = '0;
    #1;
    s_req_valid = bus.imem_req_valid;
    s_req_addr  = bus.imem_req_addr;
    if (bus.instr_valid && bus.instr_ready) begin
      dlv_pc.push_back(bus.pc_fetch); dlv_ins.push_back(bus.instr_reg_fetch);
      dlv_exp.push_back(exp_pc); dlv_cyc.push_back(cyc);
      exp_pc += 32'd4;
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      req_addr.push_back(bus.imem_req_addr); req_exp.push_back(exp_req);
      exp_req += 32'd4;
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due < last_due) due = last_due;
      last_due = due;
      mq_addr.push_back(bus.imem_req_addr); mq_due.push_back(due);
    end
    if (fire) begin
      exp_pc  = {tgt[31:2], 2'b00};
      exp_req = {tgt[31:2], 2'b00};
    end
    if (mq_addr.size() > max_out) max_out = mq_addr.size();
    if (wbus.instr_valid) begin
      w_pc.push_back(wbus.pc_fetch); w_ins.push_back(wbus.instr_reg_fetch); w_cyc.push_back(cyc);
    end
    w_pend = wbus.imem_req_valid;
    w_addr = wbus.imem_req_addr;
    if (wbus.imem_req_valid) begin
      w_req.push_back(wbus.imem_req_addr); w_req_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    assert_reset();
    #1;
    total++; if (bus.imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid); else passed++;
    total++; if (bus.imem_req_addr !== 32'h0) $display("FAIL reset_req_addr: got %h expected 00000000", bus.imem_req_addr); else passed++;
    total++; if (bus.instr_valid !== 1'b0) $display("FAIL reset_instr_valid: got %b expected 0", bus.instr_valid); else passed++;
    total++; if (bus.instr_reg_fetch !== 32'h0) $display("FAIL reset_instr: got %h expected 00000000", bus.instr_reg_fetch); else passed++;
    total++; if (bus.pc_fetch !== 32'h0) $display("FAIL reset_pc_fetch: got %h expected 00000000", bus.pc_fetch); else passed++;
    total++; if (wbus.imem_req_addr !== 32'hFFFF_FFFC) $display("FAIL reset_wrap_addr: got %h expected fffffffc", wbus.imem_req_addr); else passed++;
    @(negedge clk);
    release_reset();
    cycle();
    total++; if (s_req_valid !== 1'b0) $display("FAIL boot_no_request: got %b expected 0", s_req_valid); else passed++;
    cycle();
    total++; if (s_req_valid !== 1'b1 || s_req_addr !== 32'h0) $display("FAIL first_request: got valid %b addr %h expected 1 00000000", s_req_valid, s_req_addr); else passed++;
  endtask

  task automatic test_streaming();
    assert_reset();
    release_reset();
    repeat (10) cycle();
    total++; if (dlv_pc.size() < 4) $display("FAIL stream_count: got %0d expected >=4", dlv_pc.size()); else passed++;
    if (dlv_pc.size() >= 4) begin
      total++; if (dlv_cyc[0] !== 3) $display("FAIL stream_first_cycle: got %0d expected 3", dlv_cyc[0]); else passed++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (dlv_pc[i] !== 32'(i * 4) || dlv_ins[i] !== mem_word(32'(i * 4)))
          $display("FAIL stream_pc[%0d]: got pc %h instr %h expected pc %h instr %h", i, dlv_pc[i], dlv_ins[i], 32'(i * 4), mem_word(32'(i * 4)));
        else passed++;
      end
    end
  endtask

  // The DEPTH=4 instance ran alongside the streaming test from RESET_PC 0xFFFF_FFFC.
  task automatic test_pc_wrap();
    logic [31:0] exp;
    total++; if (w_req.size() < 2 || w_req[0] !== 32'hFFFF_FFFC || w_req_cyc[0] !== 1 || w_req[1] !== 32'h0)
      $display("FAIL wrap_requests: got %0d reqs first %h expected fffffffc at cycle 1 then 00000000", w_req.size(), (w_req.size() > 0) ? w_req[0] : 32'hx);
    else passed++;
    total++; if (w_pc.size() < 4) $display("FAIL wrap_count: got %0d expected >=4", w_pc.size()); else passed++;
    if (w_pc.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        exp = 32'hFFFF_FFFC + 32'(i * 4);
        total++;
        if (w_pc[i] !== exp || w_ins[i] !== mem_word(exp) || w_cyc[i] !== 3 + i)
          $display("FAIL wrap_pc[%0d]: got pc %h instr %h cycle %0d expected pc %h instr %h cycle %0d", i, w_pc[i], w_ins[i], w_cyc[i], exp, mem_word(exp), 3 + i);
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    assert_reset();
    release_reset();
    dec_rdy = 1'b0;
    repeat (6) cycle();
    total++; if (req_addr.size() !== 2) $display("FAIL bp_accepts: got %0d expected 2", req_addr.size()); else passed++;
    total++; if (s_req_valid !== 1'b0) $display("FAIL bp_req_dropped: got %b expected 0", s_req_valid); else passed++;
    total++; if (dlv_pc.size() !== 0) $display("FAIL bp_no_delivery: got %0d expected 0", dlv_pc.size()); else passed++;
    dec_rdy = 1'b1;
    repeat (12) cycle();
    total++; if (dlv_pc.size() < 6) $display("FAIL bp_resume_count: got %0d expected >=6", dlv_pc.size()); else passed++;
    for (int i = 0; i < dlv_pc.size(); i++) begin
      total++;
      if (dlv_pc[i] !== dlv_exp[i] || dlv_ins[i] !== mem_word(dlv_exp[i]))
        $display("FAIL bp_order[%0d]: got pc %h instr %h expected pc %h", i, dlv_pc[i], dlv_ins[i], dlv_exp[i]);
      else passed++;
    end
  endtask

  task automatic test_redirect();
    assert_reset();
    release_reset();
    lat_min = 3; lat_max = 3;
    for (int k = 0; k < 10 && mq_addr.size() < 2; k++) cycle();
    total++; if (mq_addr.size() !== 2) $display("FAIL redir_outstanding: got %0d expected 2", mq_addr.size()); else passed++;
    redir_req = 1; redir_target = 32'h0000_0103;
    cycle();
    cycle();
    total++; if (s_req_valid !== 1'b0) $display("FAIL redir_drain_quiet: got %b expected 0", s_req_valid); else passed++;
    repeat (14) cycle();
    total++; if (req_addr.size() < 3 || req_addr[2] !== 32'h100) $display("FAIL redir_next_req: got %h expected 00000100", (req_addr.size() > 2) ? req_addr[2] : 32'hx); else passed++;
    total++; if (dlv_pc.size() < 1 || dlv_pc[0] !== 32'h100) $display("FAIL redir_first_pc: got %h expected 00000100", (dlv_pc.size() > 0) ? dlv_pc[0] : 32'hx); else passed++;
    for (int i = 0; i < dlv_pc.size(); i++) begin
      total++;
      if (dlv_pc[i] !== dlv_exp[i] || dlv_ins[i] !== mem_word(dlv_exp[i]))
        $display("FAIL redir_stream[%0d]: got pc %h instr %h expected pc %h", i, dlv_pc[i], dlv_ins[i], dlv_exp[i]);
      else passed++;
    end
  endtask

  task automatic test_redirect_drain();
    assert_reset();
    release_reset();
    cycle();
    cycle();
    lat_min = 4; lat_max = 4;
    redir_on_rsp = 1; redir_target = 32'h0000_0180;
    cycle();
    total++; if (n_rsp_redir !== 1) $display("FAIL rd_simul_redirect: got %0d expected 1", n_rsp_redir); else passed++;
    redir_req = 1; redir_target = 32'h0000_0200;
    cycle();
    total++; if (s_req_valid !== 1'b0 || mq_addr.size() !== 1) $display("FAIL rd_in_drain: got valid %b inflight %0d expected 0 1", s_req_valid, mq_addr.size()); else passed++;
    lat_min = 1; lat_max = 1;
    repeat (16) cycle();
    total++; if (req_addr.size() < 3 || req_addr[2] !== 32'h200) $display("FAIL rd_next_req: got %h expected 00000200", (req_addr.size() > 2) ? req_addr[2] : 32'hx); else passed++;
    total++; if (dlv_pc.size() < 4 || dlv_pc[0] !== 32'h200) $display("FAIL rd_first_pc: got %h expected 00000200", (dlv_pc.size() > 0) ? dlv_pc[0] : 32'hx); else passed++;
    for (int i = 0; i < dlv_pc.size(); i++) begin
      total++;
      if (dlv_pc[i] !== 32'h200 + 32'(i * 4) || dlv_ins[i] !== mem_word(32'h200 + 32'(i * 4)))
        $display("FAIL rd_stream[%0d]: got pc %h instr %h expected pc %h", i, dlv_pc[i], dlv_ins[i], 32'h200 + 32'(i * 4));
      else passed++;
    end
  endtask

  task automatic test_random();
    int bad_dlv = 0;
    int bad_req = 0;
    assert_reset();
    release_reset();
    rdy_pct = 70; lat_min = 1; lat_max = 4; dec_rdy_rand = 1; redir_pct = 3;
    repeat (3000) cycle();
    for (int i = 0; i < dlv_pc.size(); i++)
      if (dlv_pc[i] !== dlv_exp[i] || dlv_ins[i] !== mem_word(dlv_exp[i])) begin
        bad_dlv++;
        if (bad_dlv <= 5) $display("note rand_stream[%0d]: got pc %h instr %h expected pc %h", i, dlv_pc[i], dlv_ins[i], dlv_exp[i]);
      end
    for (int i = 0; i < req_addr.size(); i++)
      if (req_addr[i] !== req_exp[i]) bad_req++;
    total++; if (bad_dlv !== 0) $display("FAIL rand_stream: got %0d wrong deliveries expected 0", bad_dlv); else passed++;
    total++; if (bad_req !== 0) $display("FAIL rand_req_addr: got %0d wrong request addresses expected 0", bad_req); else passed++;
    total++; if (dlv_pc.size() < 300) $display("FAIL rand_progress: got %0d deliveries expected >=300", dlv_pc.size()); else passed++;
    total++; if (max_out > 2) $display("FAIL rand_credit: got %0d outstanding expected <=2", max_out); else passed++;
    // Reset in the middle of traffic must clear the outputs at once.
    dec_rdy_rand = 0; dec_rdy = 1'b0; redir_pct = 0;
    repeat (4) cycle();
    rst = 1'b1;
    #1;
    total++; if (bus.instr_valid !== 1'b0 || bus.imem_req_valid !== 1'b0 || bus.imem_req_addr !== 32'h0)
      $display("FAIL mid_reset: got instr_valid %b req_valid %b addr %h expected 0 0 00000000", bus.instr_valid, bus.imem_req_valid, bus.imem_req_addr);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_pc_wrap();
    test_backpressure();
    test_redirect();
    test_redirect_drain();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
